// File: rtl/dist_pkg.sv
// rtl/dist_pkg.sv - shared states and constants for the echo distance to BCD path
package dist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DIVIDE,
    ST_BCD,
    ST_DONE
  } dist_state_t;

  localparam int US_PER_CM  = 58;
  localparam int MAX_CM     = 9999;
  localparam int BCD_DIGITS = 4;
  localparam int CM_W       = 14;

endpackage

// File: rtl/seq_div_const.sv
// rtl/seq_div_const.sv - restoring divider, one quotient bit per cycle, MSB first
module seq_div_const #(
  parameter int CNT_W = 32,
  parameter int DIV_W = 6
) (
  input  logic             clk_1m,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             done,
  output logic [CNT_W-1:0] quotient
);

  localparam int CW = $clog2(CNT_W);

  logic [CNT_W-1:0] dvd_q;
  logic [CNT_W-2:0] quo_q;
  logic [DIV_W-1:0] rem_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;

  logic [DIV_W:0]   trial;
  logic             qbit;

  // trial holds the shifted-in dividend bit on top of the running remainder
  always_comb begin
    trial    = {rem_q, dvd_q[CNT_W-1]};
    qbit     = (trial >= {1'b0, divisor});
    quotient = {quo_q, qbit};
    done     = run_q && (cnt_q == CW'(CNT_W - 1));
  end

  always_ff @(posedge clk_1m) begin
    if (rst) begin
      dvd_q <= '0;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (start) begin
      dvd_q <= dividend;
      quo_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      dvd_q <= {dvd_q[CNT_W-2:0], 1'b0};
      quo_q <= quotient[CNT_W-2:0];
      rem_q <= qbit ? DIV_W'(trial - {1'b0, divisor}) : trial[DIV_W-1:0];
      cnt_q <= cnt_q + 1'b1;
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/dist_to_bcd.sv
// rtl/dist_to_bcd.sv - echo width to saturated centimetres and packed BCD
module dist_to_bcd #(
  parameter int CNT_W  = 32,
  parameter int DIV    = dist_pkg::US_PER_CM,
  parameter int MAX_CM = dist_pkg::MAX_CM
) (
  input  logic             clk_1m,
  input  logic             rst,
  input  logic [CNT_W-1:0] dis_count,
  output logic [13:0]      cm,
  output logic [15:0]      bcd,
  output logic             ovf,
  output logic             valid,
  output logic             busy
);

  localparam int CM_W  = dist_pkg::CM_W;
  localparam int BCD_W = 4 * dist_pkg::BCD_DIGITS;
  localparam int SH_W  = BCD_W + CM_W;
  localparam int DIV_W = $clog2(DIV + 1);
  localparam int BC_W  = $clog2(CM_W);

  dist_pkg::dist_state_t state_q, state_d;

  logic [CNT_W-1:0] last_cnt;
  logic [SH_W-1:0]  sh_q;
  logic [CM_W-1:0]  cm_pend;
  logic             ovf_pend;
  logic [BC_W-1:0]  bit_cnt;
  logic             start;
  logic             div_done;
  logic [CNT_W-1:0] div_quo;
  logic             sat_ovf;
  logic [CM_W-1:0]  sat_val;

  seq_div_const #(
    .CNT_W (CNT_W),
    .DIV_W (DIV_W)
  ) u_div (
    .clk_1m   (clk_1m),
    .rst      (rst),
    .start    (start),
    .dividend (dis_count),
    .divisor  (DIV_W'(DIV)),
    .done     (div_done),
    .quotient (div_quo)
  );

  // One double-dabble step: add 3 to every digit >= 5, then shift left.
  function automatic logic [SH_W-1:0] dd_step(input logic [SH_W-1:0] v);
    logic [SH_W-1:0] t;
    t = v;
    for (int d = 0; d < dist_pkg::BCD_DIGITS; d++) begin
      if (t[CM_W+4*d +: 4] >= 4'd5) t[CM_W+4*d +: 4] = t[CM_W+4*d +: 4] + 4'd3;
    end
    return t << 1;
  endfunction

  always_comb begin
    sat_ovf = (div_quo > CNT_W'(MAX_CM));
    sat_val = sat_ovf ? CM_W'(MAX_CM) : div_quo[CM_W-1:0];
  end

  always_ff @(posedge clk_1m) begin
    if (rst) state_q <= dist_pkg::ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    busy    = (state_q != dist_pkg::ST_IDLE);
    case (state_q)
      dist_pkg::ST_IDLE: begin
        if (dis_count != last_cnt) begin
          start   = 1'b1;
          state_d = dist_pkg::ST_DIVIDE;
        end
      end
      dist_pkg::ST_DIVIDE: if (div_done) state_d = dist_pkg::ST_BCD;
      dist_pkg::ST_BCD:    if (bit_cnt == BC_W'(CM_W - 1)) state_d = dist_pkg::ST_DONE;
      dist_pkg::ST_DONE:   state_d = dist_pkg::ST_IDLE;
      default:             state_d = dist_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_1m) begin
    if (rst) begin
      last_cnt <= '0;
      sh_q     <= '0;
      cm_pend  <= '0;
      ovf_pend <= 1'b0;
      bit_cnt  <= '0;
      cm       <= '0;
      bcd      <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (state_q)
        dist_pkg::ST_IDLE: if (start) last_cnt <= dis_count;
        dist_pkg::ST_DIVIDE: begin
          if (div_done) begin
            sh_q     <= {{BCD_W{1'b0}}, sat_val};
            cm_pend  <= sat_val;
            ovf_pend <= sat_ovf;
            bit_cnt  <= '0;
          end
        end
        dist_pkg::ST_BCD: begin
          sh_q    <= dd_step(sh_q);
          bit_cnt <= bit_cnt + 1'b1;
        end
        dist_pkg::ST_DONE: begin
          cm    <= cm_pend;
          bcd   <= sh_q[SH_W-1:CM_W];
          ovf   <= ovf_pend;
          valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dist_to_bcd.sv
// tb/tb_dist_to_bcd.sv - directed vectors and corner sequences for dist_to_bcd
module tb_dist_to_bcd;

  typedef struct {
    logic [31:0] din;
    logic [13:0] cm;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  logic        clk_1m = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] dis_count = '0;
  logic [13:0] cm;
  logic [15:0] bcd;
  logic        ovf;
  logic        valid;
  logic        busy;

  int total = 0;
  int bad = 0;
  int vcount = 0;

  vec_t vecs[11];

  dist_to_bcd #(.CNT_W(32), .DIV(58), .MAX_CM(9999)) dut (
    .clk_1m    (clk_1m),
    .rst       (rst),
    .dis_count (dis_count),
    .cm        (cm),
    .bcd       (bcd),
    .ovf       (ovf),
    .valid     (valid),
    .busy      (busy)
  );

  always #5 clk_1m = ~clk_1m;

  always @(negedge clk_1m) if (valid) vcount++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Counts rising edges until valid is seen on a falling edge; -1 on timeout.
  task automatic wait_valid(output int lat);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 300) begin
      @(posedge clk_1m);
      lat++;
      @(negedge clk_1m);
      if (valid) seen = 1'b1;
    end
    if (!seen) lat = -1;
  endtask

  task automatic convert(input vec_t v, input int idx);
    int lat;
    @(negedge clk_1m);
    dis_count = v.din;
    @(posedge clk_1m);
    wait_valid(lat);
    check($sformatf("v%0d_latency", idx), lat, 47);
    check($sformatf("v%0d_cm", idx), cm, v.cm);
    check($sformatf("v%0d_bcd", idx), bcd, v.bcd);
    check($sformatf("v%0d_ovf", idx), ovf, v.ovf);
    check($sformatf("v%0d_busy_at_valid", idx), busy, 0);
    @(negedge clk_1m);
    check($sformatf("v%0d_valid_one_cycle", idx), valid, 0);
  endtask

  initial begin
    int lat;
    int v0;
    int seen_v;
    int seen_b;

    vecs[0]  = '{32'd580,        14'd10,   16'h0010, 1'b0};
    vecs[1]  = '{32'd57,         14'd0,    16'h0000, 1'b0};
    vecs[2]  = '{32'd58,         14'd1,    16'h0001, 1'b0};
    vecs[3]  = '{32'd115,        14'd1,    16'h0001, 1'b0};
    vecs[4]  = '{32'd116,        14'd2,    16'h0002, 1'b0};
    vecs[5]  = '{32'd579942,     14'd9999, 16'h9999, 1'b0};
    vecs[6]  = '{32'd600000,     14'd9999, 16'h9999, 1'b1};
    vecs[7]  = '{32'd1160,       14'd20,   16'h0020, 1'b0};
    vecs[8]  = '{32'd99999,      14'd1724, 16'h1724, 1'b0};
    vecs[9]  = '{32'd5800,       14'd100,  16'h0100, 1'b0};
    vecs[10] = '{32'hFFFF_FFFF,  14'd9999, 16'h9999, 1'b1};

    repeat (3) @(posedge clk_1m);
    @(negedge clk_1m);
    rst = 1'b0;
    check("rst_cm", cm, 0);
    check("rst_bcd", bcd, 0);
    check("rst_ovf", ovf, 0);
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    seen_v = 0;
    seen_b = 0;
    repeat (100) begin
      @(negedge clk_1m);
      if (valid) seen_v++;
      if (busy) seen_b++;
    end
    check("idle_no_valid", seen_v, 0);
    check("idle_no_busy", seen_b, 0);

    for (int i = 0; i < 11; i++) convert(vecs[i], i);

    // new value arriving mid-conversion is picked up afterwards
    @(negedge clk_1m);
    dis_count = 32'd580;
    @(posedge clk_1m);
    v0 = vcount;
    repeat (10) @(posedge clk_1m);
    @(negedge clk_1m);
    dis_count = 32'd1160;
    wait_valid(lat);
    check("seq1_first_timeout", (lat >= 0), 1);
    check("seq1_first_cm", cm, 10);
    wait_valid(lat);
    check("seq1_second_timeout", (lat >= 0), 1);
    check("seq1_second_cm", cm, 20);
    check("seq1_second_ovf", ovf, 0);
    repeat (60) @(negedge clk_1m);
    check("seq1_pulse_count", vcount - v0, 2);

    // value flips away and back while busy: no second conversion
    @(negedge clk_1m);
    dis_count = 32'd580;
    v0 = vcount;
    repeat (5) @(negedge clk_1m);
    dis_count = 32'd1160;
    repeat (5) @(negedge clk_1m);
    dis_count = 32'd580;
    wait_valid(lat);
    check("seq2_timeout", (lat >= 0), 1);
    check("seq2_cm", cm, 10);
    repeat (150) @(negedge clk_1m);
    check("seq2_pulse_count", vcount - v0, 1);
    check("seq2_busy", busy, 0);

    // reset during divide iteration 20 aborts, then 1160 is re-detected
    @(negedge clk_1m);
    dis_count = 32'd1160;
    @(posedge clk_1m);
    v0 = vcount;
    repeat (20) @(posedge clk_1m);
    @(negedge clk_1m);
    rst = 1'b1;
    @(posedge clk_1m);
    @(negedge clk_1m);
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_cm", cm, 0);
    check("abort_bcd", bcd, 0);
    check("abort_ovf", ovf, 0);
    wait_valid(lat);
    check("abort_redetect_latency", lat, 48);
    check("abort_redetect_cm", cm, 20);
    check("abort_redetect_bcd", bcd, 16'h0020);
    @(negedge clk_1m);
    check("abort_pulse_count", vcount - v0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 2000000");
    $fatal(1);
  end

endmodule
